// File: rtl/alu_bus_sequencer.sv
// Bus micro-cycle sequencer for ALU, MUL/DIV and HI/LO move commands on a shared datapath bus.
// Optional macro BUS_ONEHOT_CHECK_EN adds a sticky bus-conflict monitor on bus_err.
module alu_bus_sequencer #(
  parameter int NUM_REGS   = 16,
  parameter int MULDIV_LAT = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [3:0]          op,
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic [3:0]          rc,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIout,
  output logic                LOout,
  output logic                HIin,
  output logic                LOin,
  output logic [3:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_Y, S_Z, S_LO, S_HI, S_WB, S_MV, S_DONE
  } state_t;

  localparam logic [NUM_REGS-1:0] ONE_HOT_BASE = NUM_REGS'(1);
  localparam logic [3:0]          LAT_LOAD     = 4'(MULDIV_LAT - 1);

  state_t      r_state;
  logic [3:0]  r_op, r_ra, r_rb, r_rc, r_cnt;

  logic [NUM_REGS-1:0] r_rout, r_rin;
  logic r_yin, r_zin, r_zlowout, r_zhighout, r_hiout, r_loout, r_hiin, r_loin;
  logic [3:0] r_aluOp;
  logic r_busy, r_done, r_illegal;

  state_t     w_nextState;
  logic [3:0] w_nextOp, w_nextRa, w_nextRb, w_nextRc, w_nextCnt;
  logic       w_curMulDiv;

  logic [NUM_REGS-1:0] w_rout, w_rin;
  logic w_yin, w_zin, w_zlowout, w_zhighout, w_hiout, w_loout, w_hiin, w_loin;
  logic [3:0] w_aluOp;
  logic w_busy, w_done, w_illegal;

  assign w_curMulDiv = (r_op == 4'd10) || (r_op == 4'd11);

  // Next-state and command-latch logic; indices are captured only in IDLE.
  always_comb begin
    w_nextState = r_state;
    w_nextOp    = r_op;
    w_nextRa    = r_ra;
    w_nextRb    = r_rb;
    w_nextRc    = r_rc;
    w_nextCnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextOp = op;
          w_nextRa = ra;
          w_nextRb = rb;
          w_nextRc = rc;
          if (op <= 4'd7 || op == 4'd10 || op == 4'd11) w_nextState = S_Y;
          else if (op == 4'd8 || op == 4'd9)            w_nextState = S_Z;
          else if (op == 4'd12 || op == 4'd13)          w_nextState = S_MV;
          else                                          w_nextState = S_DONE;
        end
      end
      S_Y: begin
        w_nextState = S_Z;
        if (w_curMulDiv) w_nextCnt = LAT_LOAD;
      end
      S_Z: begin
        if (w_curMulDiv) begin
          if (r_cnt != 4'd0) w_nextCnt = r_cnt - 4'd1;
          else               w_nextState = S_LO;
        end else begin
          w_nextState = S_WB;
        end
      end
      S_LO:    w_nextState = S_HI;
      S_HI:    w_nextState = S_DONE;
      S_WB:    w_nextState = S_DONE;
      S_MV:    w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Strobe decode of the upcoming state so the outputs can be registered alongside it.
  always_comb begin
    w_rout      = '0;
    w_rin       = '0;
    w_yin       = 1'b0;
    w_zin       = 1'b0;
    w_zlowout   = 1'b0;
    w_zhighout  = 1'b0;
    w_hiout     = 1'b0;
    w_loout     = 1'b0;
    w_hiin      = 1'b0;
    w_loin      = 1'b0;
    w_aluOp     = 4'd0;
    w_busy      = (w_nextState != S_IDLE) && (w_nextState != S_DONE);
    w_done      = (w_nextState == S_DONE);
    w_illegal   = (w_nextState == S_DONE) && (w_nextOp >= 4'd14);
    case (w_nextState)
      S_Y: begin
        w_rout = ONE_HOT_BASE << w_nextRb;
        w_yin  = 1'b1;
      end
      S_Z: begin
        // Unary ops put rb on the bus; binary and MUL/DIV use rc as the second operand.
        if (w_nextOp == 4'd8 || w_nextOp == 4'd9) w_rout = ONE_HOT_BASE << w_nextRb;
        else                                      w_rout = ONE_HOT_BASE << w_nextRc;
        w_zin   = 1'b1;
        w_aluOp = w_nextOp;
      end
      S_WB: begin
        w_zlowout = 1'b1;
        w_rin     = ONE_HOT_BASE << w_nextRa;
      end
      S_LO: begin
        w_zlowout = 1'b1;
        w_loin    = 1'b1;
      end
      S_HI: begin
        w_zhighout = 1'b1;
        w_hiin     = 1'b1;
      end
      S_MV: begin
        w_hiout = (w_nextOp == 4'd12);
        w_loout = (w_nextOp == 4'd13);
        w_rin   = ONE_HOT_BASE << w_nextRa;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_op       <= 4'd0;
      r_ra       <= 4'd0;
      r_rb       <= 4'd0;
      r_rc       <= 4'd0;
      r_cnt      <= 4'd0;
      r_rout     <= '0;
      r_rin      <= '0;
      r_yin      <= 1'b0;
      r_zin      <= 1'b0;
      r_zlowout  <= 1'b0;
      r_zhighout <= 1'b0;
      r_hiout    <= 1'b0;
      r_loout    <= 1'b0;
      r_hiin     <= 1'b0;
      r_loin     <= 1'b0;
      r_aluOp    <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_op       <= w_nextOp;
      r_ra       <= w_nextRa;
      r_rb       <= w_nextRb;
      r_rc       <= w_nextRc;
      r_cnt      <= w_nextCnt;
      r_rout     <= w_rout;
      r_rin      <= w_rin;
      r_yin      <= w_yin;
      r_zin      <= w_zin;
      r_zlowout  <= w_zlowout;
      r_zhighout <= w_zhighout;
      r_hiout    <= w_hiout;
      r_loout    <= w_loout;
      r_hiin     <= w_hiin;
      r_loin     <= w_loin;
      r_aluOp    <= w_aluOp;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_illegal  <= w_illegal;
    end
  end

`ifdef BUS_ONEHOT_CHECK_EN
  logic [NUM_REGS+3:0] w_drivers;
  logic                w_conflict;
  logic                r_busErr;

  // Clearing the lowest set bit leaves something only when two or more drivers are active.
  assign w_drivers  = {r_rout, r_zlowout, r_zhighout, r_hiout, r_loout};
  assign w_conflict = |(w_drivers & (w_drivers - 1'b1));

  always_ff @(posedge clock) begin
    if (clear) r_busErr <= 1'b0;
    else       r_busErr <= r_busErr | w_conflict;
  end

  assign bus_err = r_busErr;
`else
  assign bus_err = 1'b0;
`endif

  assign Rout     = r_rout;
  assign Rin      = r_rin;
  assign Yin      = r_yin;
  assign Zin      = r_zin;
  assign Zlowout  = r_zlowout;
  assign Zhighout = r_zhighout;
  assign HIout    = r_hiout;
  assign LOout    = r_loout;
  assign HIin     = r_hiin;
  assign LOin     = r_loin;
  assign alu_op   = r_aluOp;
  assign busy     = r_busy;
  assign done     = r_done;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Directed, self-checking bench for alu_bus_sequencer (MULDIV_LAT=4) using hand-computed strobe vectors.
module tb_alu_bus_sequencer;

  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_YIN   = 8'h80;
  localparam logic [7:0] C_ZIN   = 8'h40;
  localparam logic [7:0] C_ZLOW  = 8'h20;
  localparam logic [7:0] C_ZHIGH = 8'h10;
  localparam logic [7:0] C_HIOUT = 8'h08;
  localparam logic [7:0] C_LOOUT = 8'h04;
  localparam logic [7:0] C_HIIN  = 8'h02;
  localparam logic [7:0] C_LOIN  = 8'h01;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [3:0]  op, ra, rb, rc;
  logic [15:0] Rout, Rin;
  logic        Yin, Zin, Zlowout, Zhighout, HIout, LOout, HIin, LOin;
  logic [3:0]  alu_op;
  logic        busy, done, illegal, bus_err;

  int evaluated = 0;
  int failures  = 0;

  alu_bus_sequencer #(.NUM_REGS(16), .MULDIV_LAT(4)) dut (
    .clock(clock), .clear(clear), .start(start),
    .op(op), .ra(ra), .rb(rb), .rc(rc),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .HIin(HIin), .LOin(LOin), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Raises start for one edge with the given command, then drops it; outputs then show cycle 1.
  task automatic applyStimulus(input logic [3:0] iOp, iRa, iRb, iRc, input logic holdStart);
    op    = iOp;
    ra    = iRa;
    rb    = iRb;
    rc    = iRc;
    start = 1'b1;
    stepCycle();
    if (!holdStart) start = 1'b0;
  endtask

  // Compares the whole output vector (including bus_err, which must stay 0) for one cycle.
  task automatic checkOutput(input string tag, input logic [15:0] eRout, eRin,
                             input logic [7:0] eCtl, input logic [3:0] eAlu,
                             input logic eBusy, eDone, eIll);
    logic [47:0] observed, expected;
    observed = {Rout, Rin, Yin, Zin, Zlowout, Zhighout, HIout, LOout, HIin, LOin,
                alu_op, busy, done, illegal, bus_err};
    expected = {eRout, eRin, eCtl, eAlu, eBusy, eDone, eIll, 1'b0};
    evaluated++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    op = 4'd0; ra = 4'd0; rb = 4'd0; rc = 4'd0;
    stepCycle();
    stepCycle();
    checkOutput("reset_state", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    stepCycle();
    checkOutput("idle_after_reset", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);

    // ADD interrupted by clear during S_Z
    applyStimulus(4'd0, 4'd3, 4'd1, 4'd2, 1'b0);
    checkOutput("abort_add_c1", 16'h0002, 16'h0, C_YIN, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("abort_add_c2", 16'h0004, 16'h0, C_ZIN, 4'd0, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    stepCycle();
    clear = 1'b0;
    checkOutput("abort_cleared", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("abort_stays_idle", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);

    // Full ADD ra=3 rb=1 rc=2
    applyStimulus(4'd0, 4'd3, 4'd1, 4'd2, 1'b0);
    checkOutput("add_c1", 16'h0002, 16'h0, C_YIN, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("add_c2", 16'h0004, 16'h0, C_ZIN, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("add_c3", 16'h0, 16'h0008, C_ZLOW, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("add_done", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("add_idle", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);

    // SUB with destination aliased to a source, and fields changed mid-sequence
    applyStimulus(4'd1, 4'd6, 4'd6, 4'd9, 1'b0);
    op = 4'd3; ra = 4'd0; rb = 4'd0; rc = 4'd0;
    checkOutput("sub_c1", 16'h0040, 16'h0, C_YIN, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("sub_c2", 16'h0200, 16'h0, C_ZIN, 4'd1, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("sub_c3", 16'h0, 16'h0040, C_ZLOW, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("sub_done", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b1, 1'b0);
    stepCycle();

    // NOT ra=5 rb=7
    applyStimulus(4'd9, 4'd5, 4'd7, 4'd3, 1'b0);
    checkOutput("not_c1", 16'h0080, 16'h0, C_ZIN, 4'd9, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("not_c2", 16'h0, 16'h0020, C_ZLOW, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("not_done", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b1, 1'b0);
    stepCycle();

    // MUL rb=2 rc=4 with MULDIV_LAT=4
    applyStimulus(4'd10, 4'd6, 4'd2, 4'd4, 1'b0);
    checkOutput("mul_c1", 16'h0004, 16'h0, C_YIN, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput($sformatf("mul_zin_%0d", i), 16'h0010, 16'h0, C_ZIN, 4'd10, 1'b1, 1'b0, 1'b0);
    end
    stepCycle();
    checkOutput("mul_lo", 16'h0, 16'h0, C_ZLOW | C_LOIN, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("mul_hi", 16'h0, 16'h0, C_ZHIGH | C_HIIN, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("mul_done_c8", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b1, 1'b0);
    stepCycle();

    // MFLO ra=15 with start held through busy and done
    applyStimulus(4'd13, 4'd15, 4'd0, 4'd0, 1'b1);
    checkOutput("mflo_c1", 16'h0, 16'h8000, C_LOOUT, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("mflo_done", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    stepCycle();
    checkOutput("mflo_single_done", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("mflo_no_rerun", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);

    // MFHI ra=0
    applyStimulus(4'd12, 4'd0, 4'd5, 4'd5, 1'b0);
    checkOutput("mfhi_c1", 16'h0, 16'h0001, C_HIOUT, 4'd0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("mfhi_done", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b1, 1'b0);
    stepCycle();

    // Reserved op 14
    applyStimulus(4'd14, 4'd1, 4'd2, 4'd3, 1'b0);
    checkOutput("reserved_done", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("reserved_idle", 16'h0, 16'h0, C_NONE, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
